// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: two-stage pixel compositor with run-time layer priority, flash overlay and per-frame hit report
//
// Optional feature macro: SPRITE_MIXER_FLASH_EN (defined = flashing overlay on overlap pixels).
//
// Ports:
//   clk         pixel/system clock
//   reset       synchronous, active-low reset
//   bright      visible-area qualifier
//   frame_start one-cycle pulse per frame (vertical blanking)
//   layer_en    per-layer pixel enable
//   layer_rgb   per-layer colour, layer i at [i*RGB_W +: RGB_W]
//   prio_wr     priority shadow table write strobe
//   prio_pos    slot to write (0 = topmost)
//   prio_layer  layer index written into that slot
//   vga_rgb     registered pixel colour, 2-cycle latency
//   hit_mask    layers that overlapped HL_LAYER during the previous frame
//   hit_valid   one-cycle pulse when hit_mask updates
module sprite_layer_mixer #(
    parameter int                  N_LAYERS  = 6,
    parameter int                  IDX_W     = 3,
    parameter int                  RGB_W     = 12,
    parameter logic [RGB_W-1:0]    BG_RGB    = 12'h69C,
    parameter logic [RGB_W-1:0]    KEY_RGB   = 12'h000,
    parameter int                  HL_LAYER  = 0,
    parameter logic [N_LAYERS-1:0] OVL_MASK  = 6'b000110,
    parameter logic [RGB_W-1:0]    FLASH_RGB = 12'hFFF,
    parameter int                  FLASH_LOG = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bright,
    input  logic                      frame_start,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic                      prio_wr,
    input  logic [IDX_W-1:0]          prio_pos,
    input  logic [IDX_W-1:0]          prio_layer,
    output logic [RGB_W-1:0]          vga_rgb,
    output logic [N_LAYERS-1:0]       hit_mask,
    output logic                      hit_valid
);
    localparam int DEPTH = 1 << IDX_W;

    logic [N_LAYERS-1:0]       eff;
    logic [N_LAYERS-1:0]       s1_eff;
    logic [N_LAYERS*RGB_W-1:0] s1_rgb;
    logic                      s1_bright;
    logic [IDX_W-1:0]          act_tbl [N_LAYERS];
    logic [IDX_W-1:0]          shd_tbl [N_LAYERS];
    logic [N_LAYERS-1:0]       hit_acc;
    logic [N_LAYERS-1:0]       hit_now;
    logic [DEPTH-1:0]          eff_pad;
    logic [RGB_W-1:0]          rgb_pad [DEPTH];
    logic [RGB_W-1:0]          win_rgb;
    logic                      ovl;
    logic                      flash_on;

    always_comb begin
        eff = '0;
        for (int i = 0; i < N_LAYERS; i++)
            eff[i] = layer_en[i] && (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB);
    end

    // Padding to the full index range makes out-of-range table entries read as
    // disabled layers, so they are skipped without an explicit range check.
    always_comb begin
        eff_pad = '0;
        eff_pad[N_LAYERS-1:0] = s1_eff;
        rgb_pad = '{default: '0};
        for (int i = 0; i < N_LAYERS; i++)
            rgb_pad[i] = s1_rgb[i*RGB_W +: RGB_W];
        win_rgb = BG_RGB;
        // Scan from the bottom slot up so the topmost effective slot wins last.
        for (int s = N_LAYERS - 1; s >= 0; s--)
            if (eff_pad[act_tbl[s]])
                win_rgb = rgb_pad[act_tbl[s]];
    end

    assign ovl     = s1_bright & s1_eff[HL_LAYER] & (|(s1_eff & OVL_MASK));
    assign hit_now = ovl ? (s1_eff & OVL_MASK) : '0;

`ifdef SPRITE_MIXER_FLASH_EN
    logic [FLASH_LOG:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign flash_on = ovl & frame_cnt[FLASH_LOG];
`else
    assign flash_on = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_eff    <= '0;
            s1_rgb    <= '0;
            s1_bright <= 1'b0;
            vga_rgb   <= '0;
            hit_acc   <= '0;
            hit_mask  <= '0;
            hit_valid <= 1'b0;
            for (int i = 0; i < N_LAYERS; i++) begin
                act_tbl[i] <= IDX_W'(i);
                shd_tbl[i] <= IDX_W'(i);
            end
        end else begin
            s1_eff    <= eff;
            s1_rgb    <= layer_rgb;
            s1_bright <= bright;
            vga_rgb   <= !s1_bright ? '0 : flash_on ? FLASH_RGB : win_rgb;
            hit_valid <= frame_start;
            if (frame_start) begin
                hit_mask <= hit_acc | hit_now;
                hit_acc  <= '0;
                act_tbl  <= shd_tbl;
            end else begin
                hit_acc <= hit_acc | hit_now;
            end
            // Non-blocking update: a coincident frame_start copies the pre-write shadow.
            for (int i = 0; i < N_LAYERS; i++)
                if (prio_wr && prio_pos == IDX_W'(i))
                    shd_tbl[i] <= prio_layer;
        end
    end
endmodule

// File: tb/tb_sprite_layer_mixer.sv
// tb_sprite_layer_mixer: directed and randomized checks of sprite_layer_mixer against a frame-level reference model
module tb_sprite_layer_mixer;
    localparam int N = 6;
    localparam int W = 12;
    localparam int HL = 0;
    localparam logic [N-1:0] OVL = 6'b000110;
`ifdef SPRITE_MIXER_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         bright = 1'b0;
    logic         frame_start = 1'b0;
    logic [N-1:0] layer_en = '0;
    logic [N*W-1:0] layer_rgb = '0;
    logic         prio_wr = 1'b0;
    logic [2:0]   prio_pos = '0;
    logic [2:0]   prio_layer = '0;
    logic [W-1:0] vga_rgb;
    logic [N-1:0] hit_mask;
    logic         hit_valid;

    int n_chk = 0;
    int n_err = 0;

    // reference model state: pixel seen one cycle ago, tables, frame count, hit report
    int           m_act [N];
    int           m_shd [N];
    logic [W-1:0] m_rgb [N];
    bit   [N-1:0] m_eff;
    bit           m_bright;
    int           m_cnt;
    bit   [N-1:0] m_acc;
    bit   [N-1:0] m_mask;
    bit           m_valid;
    logic [W-1:0] m_vga;

    sprite_layer_mixer dut (
        .clk(clk), .reset(reset), .bright(bright), .frame_start(frame_start),
        .layer_en(layer_en), .layer_rgb(layer_rgb), .prio_wr(prio_wr),
        .prio_pos(prio_pos), .prio_layer(prio_layer), .vga_rgb(vga_rgb),
        .hit_mask(hit_mask), .hit_valid(hit_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ovl;
        int win;
        bit [N-1:0] hits;
        if (!reset) begin
            m_eff = '0; m_bright = 0; m_vga = '0; m_acc = '0; m_mask = '0; m_valid = 0; m_cnt = 0;
            for (int i = 0; i < N; i++) begin
                m_rgb[i] = '0; m_act[i] = i; m_shd[i] = i;
            end
        end else begin
            ovl = m_bright && m_eff[HL] && ((m_eff & OVL) != 0);
            win = -1;
            for (int s = 0; s < N && win < 0; s++)
                if (m_act[s] < N && m_eff[m_act[s]]) win = m_act[s];
            if (!m_bright) m_vga = '0;
            else if (FLASH && ovl && ((m_cnt / 8) % 2 == 1)) m_vga = 12'hFFF;
            else if (win >= 0) m_vga = m_rgb[win];
            else m_vga = 12'h69C;
            hits = ovl ? (m_eff & OVL) : '0;
            if (frame_start) begin
                m_mask = m_acc | hits; m_acc = '0; m_valid = 1;
                for (int s = 0; s < N; s++) m_act[s] = m_shd[s];
                m_cnt = (m_cnt + 1) % 16;
            end else begin
                m_acc |= hits; m_valid = 0;
            end
            if (prio_wr && prio_pos < N) m_shd[prio_pos] = prio_layer;
            for (int i = 0; i < N; i++) begin
                m_rgb[i] = layer_rgb[i*W +: W];
                m_eff[i] = layer_en[i] && (m_rgb[i] != 12'h000);
            end
            m_bright = bright;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("vga", vga_rgb, m_vga);
        check("hmask", hit_mask, m_mask);
        check("hvld", hit_valid, m_valid);
    endtask

    task automatic clr();
        layer_en = '0;
        layer_rgb = '0;
    endtask

    task automatic px(input int i, input logic [W-1:0] c);
        layer_en[i] = 1'b1;
        layer_rgb[i*W +: W] = c;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_vga", vga_rgb, 0);
        check("rst_hmask", hit_mask, 0);
        check("rst_hvld", hit_valid, 0);
        reset = 1'b1;

        clr(); px(3, 12'hF00); px(5, 12'h0F0); bright = 1'b1;
        cyc();
        check("lat1", vga_rgb, 12'h000);
        cyc();
        check("lat2", vga_rgb, 12'hF00);

        clr(); px(1, 12'h000); px(4, 12'h00F);
        cyc(); cyc();
        check("key", vga_rgb, 12'h00F);
        clr();
        cyc(); cyc();
        check("bg", vga_rgb, 12'h69C);
        px(3, 12'hF00); bright = 1'b0;
        cyc(); cyc();
        check("blank", vga_rgb, 12'h000);
        bright = 1'b1;

        clr(); px(0, 12'h123); px(5, 12'h456);
        prio_wr = 1'b1; prio_pos = 3'd0; prio_layer = 3'd5;
        cyc();
        prio_pos = 3'd5; prio_layer = 3'd0;
        cyc();
        prio_wr = 1'b0;
        cyc();
        check("pre_swap", vga_rgb, 12'h123);
        pulse_fs();
        cyc(); cyc();
        check("swap", vga_rgb, 12'h456);
        prio_wr = 1'b1; prio_pos = 3'd0; prio_layer = 3'd0; frame_start = 1'b1;
        cyc();
        prio_wr = 1'b0; frame_start = 1'b0;
        cyc(); cyc();
        check("defer", vga_rgb, 12'h456);
        pulse_fs();
        cyc(); cyc();
        check("restore", vga_rgb, 12'h123);

        pulse_fs();
        clr(); px(0, 12'h111); px(1, 12'h222);
        repeat (3) cyc();
        clr(); px(3, 12'h333);
        cyc(); cyc();
        pulse_fs();
        check("hit", hit_mask, 6'b000010);
        check("hit_v", hit_valid, 1);
        cyc();
        check("hit_v0", hit_valid, 0);
        repeat (3) cyc();
        pulse_fs();
        check("nohit", hit_mask, 6'b000000);

        clr(); px(0, 12'hAAA); px(2, 12'hBBB);
        for (int f = 0; f < 20; f++) begin
            repeat (3) cyc();
            check("ovl", vga_rgb, (FLASH && ((m_cnt / 8) % 2 == 1)) ? 12'hFFF : 12'hAAA);
            pulse_fs();
        end

        prio_wr = 1'b1; prio_pos = 3'd0; prio_layer = 3'd2;
        cyc();
        prio_wr = 1'b0;
        pulse_fs();
        repeat (3) cyc();
        pulse_fs();
        cyc();
        reset = 1'b0;
        cyc();
        check("mrst_vga", vga_rgb, 0);
        check("mrst_hmask", hit_mask, 0);
        check("mrst_hvld", hit_valid, 0);
        reset = 1'b1;
        cyc();
        check("rel1", vga_rgb, 0);
        cyc();
        check("ident", vga_rgb, 12'hAAA);

        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) != 0);
            bright = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                layer_en[i] = 1'($urandom);
                layer_rgb[i*W +: W] = ($urandom_range(0, 3) == 0) ? 12'h000 : W'($urandom);
            end
            frame_start = ($urandom_range(0, 15) == 0);
            prio_wr = ($urandom_range(0, 7) == 0);
            prio_pos = 3'($urandom);
            prio_layer = 3'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
